// File: rtl/shift_pkg.sv
// Shared types for the shift sequencer: shift modes and controller states.
package shift_pkg;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        ROL = 2'b10,
        ROR = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } seq_state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Job request / result handshake between a requester and the shift sequencer.
interface shift_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic                    start_valid;
    logic                    start_ready;
    logic [WIDTH-1:0]        operand;
    logic [CNT_W-1:0]        amount;
    shift_pkg::shift_mode_t  mode;
    logic [WIDTH-1:0]        result;
    logic                    carry;
    logic                    busy;
    logic                    done;
    logic                    result_ready;

    modport master (
        output start_valid, operand, amount, mode, result_ready,
        input  start_ready, result, carry, busy, done
    );

    modport slave (
        input  start_valid, operand, amount, mode, result_ready,
        output start_ready, result, carry, busy, done
    );

endinterface

// File: rtl/shift1_unit.sv
// One-position shift/rotate stage; out_bit is the bit that leaves (or wraps).
module shift1_unit
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  shift_mode_t      mode,
    output logic [WIDTH-1:0] next_value,
    output logic             out_bit
);

    always_comb begin
        next_value = value;
        out_bit    = 1'b0;
        case (mode)
            SLL: begin
                next_value = {value[WIDTH-2:0], 1'b0};
                out_bit    = value[WIDTH-1];
            end
            SRL: begin
                next_value = {1'b0, value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            ROL: begin
                next_value = {value[WIDTH-2:0], value[WIDTH-1]};
                out_bit    = value[WIDTH-1];
            end
            ROR: begin
                next_value = {value[0], value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: steps shift1_unit once per clock for `amount` edges
// and holds the result until the consumer acknowledges it.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_sequencer_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    seq_state_t       state_q;
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] count_q;
    shift_mode_t      mode_q;
    logic             carry_q;

    logic [WIDTH-1:0] shifted;
    logic             shift_out;

    shift1_unit #(
        .WIDTH (WIDTH)
    ) u_shift1 (
        .value      (result_q),
        .mode       (mode_q),
        .next_value (shifted),
        .out_bit    (shift_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            count_q  <= '0;
            mode_q   <= SLL;
            carry_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_valid) begin
                        result_q <= bus.operand;
                        count_q  <= bus.amount;
                        mode_q   <= bus.mode;
                        carry_q  <= 1'b0;
                        state_q  <= (bus.amount == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    result_q <= shifted;
                    carry_q  <= shift_out;
                    count_q  <= count_q - CNT_W'(1);
                    // Last step: the counter is about to reach zero.
                    if (count_q == CNT_W'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.busy        = (state_q == SHIFT);
    assign bus.done        = (state_q == DONE);
    assign bus.result      = result_q;
    assign bus.carry       = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: table-driven jobs, random jobs, and
// hand-written reset, backpressure and input-churn sequences.
module tb_shift_sequencer;
    import shift_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    shift_sequencer_if #(.WIDTH(WIDTH)) bus ();

    shift_sequencer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [WIDTH-1:0] operand;
        logic [CNT_W-1:0] amount;
        shift_mode_t      mode;
        logic [WIDTH-1:0] exp_result;
        logic             exp_carry;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] result;
        logic             carry;
        int               latency;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Closed-form reference for an amount-position shift/rotate.
    function automatic exp_t model(input logic [WIDTH-1:0] op, input logic [CNT_W-1:0] amt,
                                   input shift_mode_t m);
        exp_t e;
        int   a;
        a         = int'(amt);
        e.latency = a;
        e.result  = op;
        e.carry   = 1'b0;
        if (a != 0) begin
            case (m)
                SLL: begin e.result = op << a; e.carry = op[WIDTH-a]; end
                SRL: begin e.result = op >> a; e.carry = op[a-1]; end
                ROL: begin e.result = (op << a) | (op >> (WIDTH-a)); e.carry = op[WIDTH-a]; end
                ROR: begin e.result = (op >> a) | (op << (WIDTH-a)); e.carry = op[a-1]; end
                default: ;
            endcase
        end
        return e;
    endfunction

    task automatic randomize_inputs();
        bus.operand = WIDTH'($urandom);
        bus.amount  = CNT_W'($urandom);
        bus.mode    = shift_mode_t'($urandom_range(0, 3));
    endtask

    // Accept one job, wait for done, compare against the scoreboard head; leaves DUT in DONE.
    task automatic run_job(input logic [WIDTH-1:0] op, input logic [CNT_W-1:0] amt,
                           input shift_mode_t m, input bit churn);
        exp_t e;
        int   t;
        int   lat;
        t = 0;
        while (!bus.start_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("start_ready before job", 32'(bus.start_ready), 32'd1);
        bus.operand     = op;
        bus.amount      = amt;
        bus.mode        = m;
        bus.start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
        lat = 0;
        while (!bus.done && lat < 20) begin
            if (churn) begin
                randomize_inputs();
                bus.start_valid  = 1'($urandom);
                bus.result_ready = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        bus.start_valid  = 1'b0;
        bus.result_ready = 1'b0;
        if (sb.size() == 0) begin
            check("scoreboard underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("done latency", 32'(lat), 32'(e.latency));
            check("result", 32'(bus.result), 32'(e.result));
            check("carry", 32'(bus.carry), 32'(e.carry));
            check("busy low in done", 32'(bus.busy), 32'd0);
            check("start_ready low in done", 32'(bus.start_ready), 32'd0);
        end
    endtask

    task automatic ack();
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        check("done cleared after ack", 32'(bus.done), 32'd0);
        check("start_ready after ack", 32'(bus.start_ready), 32'd1);
    endtask

    initial begin
        exp_t e;
        logic [WIDTH-1:0] op;
        logic [CNT_W-1:0] amt;
        shift_mode_t      m;

        vecs[0] = '{8'b0000_0011, 3'd3, SLL, 8'b0001_1000, 1'b0};
        vecs[1] = '{8'b1000_0001, 3'd1, ROL, 8'b0000_0011, 1'b1};
        vecs[2] = '{8'b1000_0001, 3'd1, ROR, 8'b1100_0000, 1'b1};
        vecs[3] = '{8'b1011_0101, 3'd7, SRL, 8'b0000_0001, 1'b0};
        vecs[4] = '{8'b1011_0101, 3'd0, SRL, 8'b1011_0101, 1'b0};
        vecs[5] = '{8'b1011_0101, 3'd4, ROL, 8'b0101_1011, 1'b1};
        vecs[6] = '{8'b1011_0101, 3'd3, ROR, 8'b1011_0110, 1'b1};
        vecs[7] = '{8'b1111_1111, 3'd7, SLL, 8'b1000_0000, 1'b1};

        bus.start_valid  = 1'b0;
        bus.result_ready = 1'b0;
        bus.operand      = '0;
        bus.amount       = '0;
        bus.mode         = SLL;

        #2 rst_n = 1'b0;
        #1;
        check("reset result", 32'(bus.result), 32'd0);
        check("reset carry", 32'(bus.carry), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset start_ready", 32'(bus.start_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            sb.push_back('{vecs[i].exp_result, vecs[i].exp_carry, int'(vecs[i].amount)});
            run_job(vecs[i].operand, vecs[i].amount, vecs[i].mode, 1'b0);
            ack();
        end

        // Reset two shift edges into an SLL-by-5 job.
        bus.operand     = 8'h5A;
        bus.amount      = 3'd5;
        bus.mode        = SLL;
        bus.start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy before mid-job reset", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid reset result", 32'(bus.result), 32'd0);
        check("mid reset carry", 32'(bus.carry), 32'd0);
        check("mid reset busy", 32'(bus.busy), 32'd0);
        check("mid reset done", 32'(bus.done), 32'd0);
        check("mid reset start_ready", 32'(bus.start_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sb.push_back(model(8'h5A, 3'd5, SLL));
        run_job(8'h5A, 3'd5, SLL, 1'b0);
        ack();

        // Backpressure: hold DONE while new jobs are offered.
        e = model(8'hC3, 3'd2, ROR);
        sb.push_back(e);
        run_job(8'hC3, 3'd2, ROR, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.operand     = WIDTH'($urandom);
            bus.amount      = 3'd1;
            bus.start_valid = 1'b1;
            @(negedge clk);
            check("bp done held", 32'(bus.done), 32'd1);
            check("bp result held", 32'(bus.result), 32'(e.result));
            check("bp carry held", 32'(bus.carry), 32'(e.carry));
            check("bp no accept", 32'(bus.start_ready), 32'd0);
        end
        bus.start_valid = 1'b0;
        ack();
        @(negedge clk);
        check("idle after bp", 32'(bus.start_ready), 32'd1);

        // Random jobs, with input churn on odd iterations.
        for (int i = 0; i < 12; i++) begin
            op  = WIDTH'($urandom);
            amt = CNT_W'($urandom);
            m   = shift_mode_t'($urandom_range(0, 3));
            sb.push_back(model(op, amt, m));
            run_job(op, amt, m, i[0]);
            ack();
        end

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
